// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory and
// loads the IF/ID register {Curr_Pc, Curr_Instr}, absorbing stalls with a one-entry skid buffer.
module if_fetch_stage #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = 9'h000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [PC_W+31:0]   if_id_q,
  output logic               if_id_valid
);

  localparam logic [PC_W-1:0]  ALIGN_MASK = ~(PC_W'(2'b11));
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(3'd4);
  localparam logic [PC_W+31:0] BUBBLE     = {{PC_W{1'b0}}, NOP_INSTR};

  logic [PC_W-1:0]  pc_r;
  logic             rsp_valid_r;
  logic [PC_W-1:0]  rsp_pc_r;
  logic             skid_valid_r;
  logic [PC_W+31:0] skid_r;

  logic [PC_W-1:0]  target_s;
  logic [PC_W-1:0]  imem_addr_s;
  logic             issue_s;
  logic [PC_W+31:0] rsp_word_s;

  // Issue address: a redirect target bypasses the PC in the same cycle.
  always_comb begin
    target_s   = redirect_pc & ALIGN_MASK;
    rsp_word_s = {rsp_pc_r, imem_rdata};
    issue_s    = !reset && (redirect || !stall);
    if (redirect) begin
      imem_addr_s = target_s;
    end else begin
      imem_addr_s = pc_r;
    end
  end

  assign imem_addr = imem_addr_s;

  // PC and in-flight response tracking; the add wraps naturally at 2^PC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_PC;
      rsp_valid_r <= 1'b0;
      rsp_pc_r    <= {PC_W{1'b0}};
    end else begin
      rsp_valid_r <= issue_s;
      if (issue_s) begin
        rsp_pc_r <= imem_addr_s;
        pc_r     <= imem_addr_s + PC_STEP;
      end else begin
        rsp_pc_r <= rsp_pc_r;
        pc_r     <= pc_r;
      end
    end
  end

  // IF/ID register and skid buffer: redirect squashes, stall parks the arriving word.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q      <= BUBBLE;
      if_id_valid  <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_r       <= BUBBLE;
    end else if (redirect) begin
      if_id_q      <= BUBBLE;
      if_id_valid  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (stall) begin
      if (rsp_valid_r && !skid_valid_r) begin
        skid_r       <= rsp_word_s;
        skid_valid_r <= 1'b1;
      end else begin
        skid_r       <= skid_r;
        skid_valid_r <= skid_valid_r;
      end
    end else if (skid_valid_r) begin
      if_id_q      <= skid_r;
      if_id_valid  <= 1'b1;
      skid_valid_r <= 1'b0;
    end else if (rsp_valid_r) begin
      if_id_q     <= rsp_word_s;
      if_id_valid <= 1'b1;
    end else begin
      if_id_q     <= BUBBLE;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan scenarios with literal
// expectations, then randomized stall/redirect/reset traffic against a fetch-stream model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [40:0] if_id_q;
  logic        if_id_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_q     (if_id_q),
    .if_id_valid (if_id_valid)
  );

  // Synchronous-read instruction memory, 128 words.
  logic [31:0] mem [0:127];
  always @(posedge clk) imem_rdata <= mem[imem_addr[8:2]];

  task automatic chk(input string name, input logic [40:0] got, input logic [40:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Fetch-stream model: a queue of issued-but-undelivered addresses.
  logic [8:0]  m_next;
  logic [8:0]  m_q [$];
  logic [40:0] m_out;
  logic        m_valid;
  logic        m_known = 1'b0;
  logic [8:0]  m_exp_addr;
  logic [8:0]  m_tgt;
  logic [8:0]  m_p;

  initial begin
    forever begin
      @(negedge clk);
      m_tgt = redirect_pc & 9'h1FC;
      if (m_known) begin
        m_exp_addr = redirect ? m_tgt : m_next;
        chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_exp_addr});
        chk("if_id_q", if_id_q, m_out);
        chk("if_id_valid", {40'd0, if_id_valid}, {40'd0, m_valid});
      end
      if (reset) begin
        m_q.delete();
        m_out   = {9'h000, NOP};
        m_valid = 1'b0;
        m_next  = 9'h000;
        m_known = 1'b1;
      end else if (redirect) begin
        m_q.delete();
        m_out   = {9'h000, NOP};
        m_valid = 1'b0;
        m_q.push_back(m_tgt);
        m_next  = m_tgt + 9'd4;
      end else if (!stall) begin
        if (m_q.size() > 0) begin
          m_p     = m_q.pop_front();
          m_out   = {m_p, mem[m_p[8:2]]};
          m_valid = 1'b1;
        end else begin
          m_out   = {9'h000, NOP};
          m_valid = 1'b0;
        end
        m_q.push_back(m_next);
        m_next = m_next + 9'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [8:0] pc, input logic [31:0] instr,
                          input logic vld);
    chk({name, "_q"}, if_id_q, {pc, instr});
    chk({name, "_v"}, {40'd0, if_id_valid}, {40'd0, vld});
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'h100 + k;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 9'h000;
    tick(); tick(); tick();

    // Boot
    reset = 1'b0; #1;
    chk("boot_addr0", {32'd0, imem_addr}, {32'd0, 9'h000});
    chk_ifid("boot_reset", 9'h000, NOP, 1'b0);
    tick(); chk("boot_addr1", {32'd0, imem_addr}, {32'd0, 9'h004});
    tick(); chk_ifid("boot_first", 9'h000, 32'h100, 1'b1);
    tick(); chk_ifid("boot_second", 9'h004, 32'h101, 1'b1);
    tick(); chk_ifid("pre_stall", 9'h008, 32'h102, 1'b1);

    // Stall for 3 cycles
    stall = 1'b1;
    tick(); chk_ifid("stall_hold1", 9'h008, 32'h102, 1'b1);
    chk("stall_addr", {32'd0, imem_addr}, {32'd0, 9'h010});
    tick(); chk_ifid("stall_hold2", 9'h008, 32'h102, 1'b1);
    tick(); stall = 1'b0; #1;
    chk_ifid("stall_hold3", 9'h008, 32'h102, 1'b1);
    chk("release_addr", {32'd0, imem_addr}, {32'd0, 9'h010});
    tick(); chk_ifid("release_skid", 9'h00C, 32'h103, 1'b1);
    tick(); chk_ifid("release_next", 9'h010, 32'h104, 1'b1);

    // Redirect to 0x043 (aligned to 0x040)
    redirect = 1'b1; redirect_pc = 9'h043; #1;
    chk("redir_addr", {32'd0, imem_addr}, {32'd0, 9'h040});
    tick(); redirect = 1'b0;
    chk_ifid("redir_bubble", 9'h000, NOP, 1'b0);
    tick(); chk_ifid("redir_t0", 9'h040, 32'h110, 1'b1);
    tick(); chk_ifid("redir_t1", 9'h044, 32'h111, 1'b1);

    // Two-cycle stall with skid full, then redirect+stall together
    stall = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 9'h080;
    tick(); redirect = 1'b0; stall = 1'b0;
    chk_ifid("rs_bubble", 9'h000, NOP, 1'b0);
    tick(); chk_ifid("rs_t0", 9'h080, 32'h120, 1'b1);
    tick(); chk_ifid("rs_t1", 9'h084, 32'h121, 1'b1);

    // Wrap-around
    redirect = 1'b1; redirect_pc = 9'h1F8;
    tick(); redirect = 1'b0;
    chk_ifid("wrap_bubble", 9'h000, NOP, 1'b0);
    tick(); chk_ifid("wrap_1f8", 9'h1F8, 32'h17E, 1'b1);
    tick(); chk_ifid("wrap_1fc", 9'h1FC, 32'h17F, 1'b1);
    tick(); chk_ifid("wrap_000", 9'h000, 32'h100, 1'b1);
    tick(); chk_ifid("wrap_004", 9'h004, 32'h101, 1'b1);

    // Reset during a stall with the skid full
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0; stall = 1'b0; #1;
    chk_ifid("rst_stall", 9'h000, NOP, 1'b0);
    chk("rst_addr", {32'd0, imem_addr}, {32'd0, 9'h000});
    tick(); chk_ifid("rst_gap", 9'h000, NOP, 1'b0);
    tick(); chk_ifid("rst_first", 9'h000, 32'h100, 1'b1);
    tick(); chk_ifid("rst_second", 9'h004, 32'h101, 1'b1);

    // Randomized traffic with fresh memory contents loaded under reset
    reset = 1'b1;
    tick();
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) < 1);
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 10);
      redirect_pc = 9'($urandom);
      tick();
    end
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
